uart_tx_slave: RTL and testbench

Memory-mapped 8N1 UART transmitter sitting on the naive_bus as a slave, downstream of the core's bus master port. The core writes bytes into a 16-entry TX FIFO, and a bit-timing state machine serialises them onto `uart_tx`. When the FIFO is full, writes are back-pressured by withholding `wr_gnt`, which stalls the core through its conflict signal. A status register lets software poll FIFO level and busy state.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_slave_if.sv | 25 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_slave.sv | 152 +++++++++++++++
 tb/tb_uart_tx_slave.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types, register offsets and STATUS layout for uart_tx_slave
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic [31:0] UART_TXDATA_OFS = 32'h0;
  localparam logic [31:0] UART_DIV_OFS    = 32'h4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/uart_tx_slave_if.sv
// rtl/uart_tx_slave_if.sv - naive_bus read/write request-grant bus
interface naive_bus;

  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [3:0]  rd_be;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and fall-through read data
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == DEPTH);
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - memory-mapped 8N1 UART transmitter with TX FIFO on naive_bus
module uart_tx_slave
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  naive_bus.slave  bus,
  output logic     uart_tx
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic               push;
  logic               pop;
  logic [7:0]         dout;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   count;
  logic [31:0]        status;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  uart_tx_state_t state, state_nxt;
  logic [15:0]    div_cnt, div_nxt;
  logic [2:0]     bit_idx, bit_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           tx_nxt;
  logic           bit_end;

  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.wr_data[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Only a TXDATA byte write can be refused, and only on the registered full flag.
  assign bus.rd_gnt = bus.rd_req;
  assign bus.wr_gnt = bus.wr_req &
                      ~((bus.wr_addr[2] == UART_TXDATA_OFS[2]) & bus.wr_be[0] & full);
  assign push = bus.wr_req & bus.wr_gnt & (bus.wr_addr[2] == UART_TXDATA_OFS[2]) & bus.wr_be[0];

  always_comb begin
    status = '0;
    status[STAT_FULL_BIT]  = full;
    status[STAT_EMPTY_BIT] = empty;
    status[STAT_BUSY_BIT]  = (state != IDLE);
    status[STAT_COUNT_LSB +: FIFO_AW+1] = count;
    rd_mux = (bus.rd_addr[2] == UART_DIV_OFS[2]) ? 32'(CLK_DIV) : status;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
    end else if (bus.rd_req) begin
      bus.rd_data <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      uart_tx <= tx_nxt;
    end
  end

  assign bit_end = (div_cnt == DIV_LAST);

  // tx_nxt is the line level for the state being entered, so uart_tx stays registered.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt + 16'd1;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        tx_nxt  = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = dout;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          div_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          div_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = dout;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  assign unused_bits = &{1'b0, bus.rd_addr[31:3], bus.rd_addr[1:0], bus.rd_be,
                         bus.wr_addr[31:3], bus.wr_addr[1:0], bus.wr_be[3:1],
                         bus.wr_data[31:8]};

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb/tb_uart_tx_slave.sv - directed self-checking bench for uart_tx_slave
module tb_uart_tx_slave;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   cyc = 0;
  int   rst_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_bad = 0;

  naive_bus bus_if();

  uart_tx_slave #(.CLK_DIV(DIV), .FIFO_AW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .uart_tx (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rst_cnt <= rst_cnt + 1;
  end

  // Line receiver: samples mid-bit, drops any frame that saw a reset.
  initial begin : rx_mon
    int s;
    int r0;
    logic [7:0] b;
    logic st;
    logic sp;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        s  = cyc;
        r0 = rst_cnt;
        repeat (DIV/2) @(negedge clk);
        st = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (DIV) @(negedge clk);
        sp = tx;
        repeat (DIV/2 - 1) @(negedge clk);
        if (rst_cnt == r0) begin
          if (st !== 1'b0 || sp !== 1'b1) rx_bad++;
          else begin
            rx_q.push_back(b);
            rx_start.push_back(s);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] data, output int stalls);
    logic g;
    g = 1'b0;
    stalls = 0;
    @(negedge clk);
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = addr;
    bus_if.wr_be   = be;
    bus_if.wr_data = data;
    for (int i = 0; i < 200 && !g; i++) begin
      #1 g = bus_if.wr_gnt;
      @(posedge clk);
      if (!g) begin
        stalls++;
        @(negedge clk);
      end
    end
    #1 bus_if.wr_req = 1'b0;
    n_cmp++;
    if (!g) begin
      n_bad++;
      $display("FAIL wr_grant_timeout addr=%h got gnt=0 required gnt=1", addr);
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = addr;
    bus_if.rd_be   = 4'hf;
    #1;
    n_cmp++;
    if (bus_if.rd_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_gnt got %b required 1", bus_if.rd_gnt);
    end
    @(posedge clk);
    #1 bus_if.rd_req = 1'b0;
    data = bus_if.rd_data;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(32'h0, d);
    n_cmp++;
    if (d !== exp) begin
      n_bad++;
      $display("FAIL %s status got %h required %h", name, d, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rx_q.size() < n) begin
      n_bad++;
      $display("FAIL wait_rx got %0d frames required %0d", rx_q.size(), n);
    end
  endtask

  task automatic check_frames(input int base, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (rx_q[base+i] !== exp[i]) begin
        n_bad++;
        $display("FAIL rx_byte[%0d] got %h required %h", i, rx_q[base+i], exp[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (rx_start[base+i] - rx_start[base+i-1] != 10*DIV) begin
          n_bad++;
          $display("FAIL frame_gap[%0d] got %0d required %0d", i,
                   rx_start[base+i] - rx_start[base+i-1], 10*DIV);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus_if.rd_req = 1'b0; bus_if.rd_addr = '0; bus_if.rd_be = '0;
    bus_if.wr_req = 1'b0; bus_if.wr_addr = '0; bus_if.wr_be = '0; bus_if.wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b required 1", tx); end
    n_cmp++;
    if (bus_if.rd_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_rd_data got %h required 0", bus_if.rd_data);
    end
    n_cmp++;
    if (bus_if.rd_gnt !== 1'b0 || bus_if.wr_gnt !== 1'b0) begin
      n_bad++; $display("FAIL reset_gnt got %b%b required 00", bus_if.rd_gnt, bus_if.wr_gnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_registers();
    logic [31:0] d;
    check_status("after_reset", 32'h0000_0002);
    bus_read(32'h4, d);
    n_cmp++;
    if (d !== 32'd4) begin n_bad++; $display("FAIL div_reg got %h required 4", d); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus_if.rd_data !== 32'd4) begin
      n_bad++; $display("FAIL rd_data_hold got %h required 4", bus_if.rd_data);
    end
  endtask

  task automatic test_single_frame();
    int st;
    int base;
    logic [7:0] byt;
    logic [9:0] frame;
    base  = rx_q.size();
    byt   = 8'h55;
    frame = {1'b1, byt, 1'b0};
    bus_write(32'h0, 4'b0001, 32'h55, st);
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_write_edge got %b required 1", tx); end
    for (int i = 0; i < 10*DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== frame[i/DIV]) begin
        n_bad++; $display("FAIL tx_bit cycle=%0d got %b required %b", i, tx, frame[i/DIV]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after got %b required 1", tx); end
    check_status("after_frame", 32'h0000_0002);
    wait_rx(base + 1, 20);
    check_frames(base, '{8'h55});
  endtask

  task automatic test_ignored_writes();
    int st;
    int hi;
    logic [31:0] d;
    bus_write(32'h0, 4'b0010, 32'hAA, st);
    n_cmp++;
    if (st != 0) begin n_bad++; $display("FAIL be_noload_stall got %0d required 0", st); end
    check_status("be_noload", 32'h0000_0002);
    bus_write(32'h4, 4'b0001, 32'h12, st);
    check_status("div_write", 32'h0000_0002);
    bus_read(32'h4, d);
    n_cmp++;
    if (d !== 32'd4) begin n_bad++; $display("FAIL div_after_write got %h required 4", d); end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    n_cmp++;
    if (hi != 20) begin n_bad++; $display("FAIL ignored_line_idle got %0d high required 20", hi); end
  endtask

  task automatic test_back_to_back();
    int st;
    int tot;
    int base;
    logic [7:0] exp[$];
    base = rx_q.size();
    tot  = 0;
    for (int i = 0; i < 17; i++) begin
      bus_write(32'h0, 4'b0001, 32'(8'h10 + i), st);
      tot += st;
      exp.push_back(8'(8'h10 + i));
    end
    n_cmp++;
    if (tot > 1) begin n_bad++; $display("FAIL b2b_first17_stalls got %0d required <=1", tot); end
    check_status("full", 32'h0000_1005);
    for (int i = 0; i < 2; i++) begin
      bus_write(32'h0, 4'b0001, 32'(8'h21 + i), st);
      exp.push_back(8'(8'h21 + i));
      n_cmp++;
      if (st < 1 || st > 10*DIV) begin
        n_bad++; $display("FAIL full_stall[%0d] got %0d required 1..%0d", i, st, 10*DIV);
      end
    end
    wait_rx(base + 19, 19*10*DIV + 100);
    check_frames(base, exp);
    check_status("b2b_done", 32'h0000_0002);
  endtask

  task automatic test_collision();
    int st;
    int c0;
    int base;
    logic [7:0] exp[$];
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      bus_write(32'h0, 4'b0001, 32'(8'h30 + i), st);
      if (i == 0) c0 = cyc;
      exp.push_back(8'(8'h30 + i));
    end
    check_status("count5", 32'h0000_0504);
    while (cyc < c0 + 10*DIV - 1) @(negedge clk);
    bus_write(32'h0, 4'b0001, 32'h36, st);
    exp.push_back(8'h36);
    n_cmp++;
    if (cyc != c0 + 10*DIV + 1) begin
      n_bad++; $display("FAIL collide_edge got %0d required %0d", cyc - c0, 10*DIV + 1);
    end
    check_status("collide_count", 32'h0000_0504);
    wait_rx(base + 7, 7*10*DIV + 100);
    check_frames(base, exp);
  endtask

  task automatic test_reset_mid_frame();
    int st;
    int c0;
    int base;
    int hi;
    base = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      bus_write(32'h0, 4'b0001, 32'(8'hA1 + i), st);
      if (i == 0) c0 = cyc;
    end
    while (cyc < c0 + 15) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL midreset_tx got %b required 1", tx); end
    rst_n = 1'b1;
    check_status("midreset", 32'h0000_0002);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    n_cmp++;
    if (hi != 200) begin n_bad++; $display("FAIL midreset_idle got %0d high required 200", hi); end
    n_cmp++;
    if (rx_q.size() != base) begin
      n_bad++; $display("FAIL midreset_frames got %0d required %0d", rx_q.size(), base);
    end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_single_frame();
    test_ignored_writes();
    test_back_to_back();
    test_collision();
    test_reset_mid_frame();
    n_cmp++;
    if (rx_bad != 0) begin n_bad++; $display("FAIL framing_errors got %0d required 0", rx_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
